addsub_seq_16bit: RTL and testbench

Multi-cycle 16-bit add/subtract unit built around a single shared 4-bit nibble adder slice. A controller FSM latches operands on a start request and feeds one nibble per cycle through the slice, propagating carry in a register. It then publishes the full-width result and flags (overflow, carry, zero, negative) with a one-cycle done pulse. Used by the ALU for wide arithmetic where area matters more than latency.

---
 rtl/addsub_seq_16bit_pkg.sv | 25 ++
 rtl/addsub_nibble.sv | 35 +++
 rtl/addsub_seq_16bit.sv | 147 ++++++++++++++
 tb/tb_addsub_seq_16bit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_seq_16bit_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit.
//   - FSM state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   - default slice and operand widths
//   - helpers deriving the RUN step count and step-counter width
package addsub_seq_16bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NIB_DEF   = 4;
  localparam int WIDTH_DEF = 16;

  function automatic int nstep_of(input int width, input int nib);
    return width / nib;
  endfunction

  // A one-step machine still needs a 1-bit counter.
  function automatic int step_bits(input int nstep);
    return (nstep > 1) ? $clog2(nstep) : 1;
  endfunction

endpackage

// File: rtl/addsub_nibble.sv
// Combinational NIB-bit ripple-carry adder slice.
// Ports:
//   a, b    in  NIB  nibble operands
//   cin     in  1    carry in
//   sum     out NIB  nibble sum
//   cout    out 1    carry out of the slice MSB
//   c_msb   out 1    carry into the slice MSB (for signed overflow)
module addsub_nibble
  import addsub_seq_16bit_pkg::*;
#(
  parameter int NIB = NIB_DEF
) (
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB-1:0] sum,
  output logic           cout,
  output logic           c_msb
);

  logic [NIB:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < NIB; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout  = c[NIB];
    c_msb = c[NIB-1];
  end

endmodule

// File: rtl/addsub_seq_16bit.sv
// Multi-cycle WIDTH-bit add/subtract built around one shared NIB-bit slice.
// One nibble is processed per RUN cycle, least significant first, with the
// carry held in a register between steps.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             request, honoured only when not busy
//   sub               0: A+B, 1: A-B
//   A, B              operands, latched on an accepted start
//   busy              high while in RUN
//   done              one-cycle pulse when Sum/flags are published
//   Sum               result register
//   Ovfl, Cout        signed overflow, carry out of MSB (1 = no borrow on sub)
//   Zero, Neg         Sum == 0, Sum MSB
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start
// ST_RUN  | one nibble per cycle through the slice, busy=1
// ST_DONE | result published, done=1; start here is accepted directly
module addsub_seq_16bit
  import addsub_seq_16bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NIB   = NIB_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Ovfl,
  output logic             Cout,
  output logic             Zero,
  output logic             Neg
);

  localparam int NSTEP = nstep_of(WIDTH, NIB);
  localparam int SW    = step_bits(NSTEP);
  localparam logic [SW-1:0] LAST_STEP = SW'(NSTEP - 1);

  state_t state_q, state_d;

  logic [SW-1:0]    step_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bop_q;   // B already inverted for subtraction
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             carry_q; // starts at sub, completing the two's complement

  logic             accept;
  logic             last_step;
  logic [NIB-1:0]   nib_a, nib_b, nib_sum;
  logic             nib_cout, nib_cmsb;

  always_comb begin
    nib_a = a_q[int'(step_q)*NIB +: NIB];
    nib_b = bop_q[int'(step_q)*NIB +: NIB];
  end

  addsub_nibble #(.NIB(NIB)) u_nibble (
    .a     (nib_a),
    .b     (nib_b),
    .cin   (carry_q),
    .sum   (nib_sum),
    .cout  (nib_cout),
    .c_msb (nib_cmsb)
  );

  // Accumulator including the current step's nibble, so the final step can
  // publish the complete result on the same edge it is produced.
  always_comb begin
    acc_d = acc_q;
    acc_d[int'(step_q)*NIB +: NIB] = nib_sum;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (step_q == LAST_STEP) begin
          last_step = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      a_q     <= '0;
      bop_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      Sum     <= '0;
      Ovfl    <= 1'b0;
      Cout    <= 1'b0;
      Zero    <= 1'b0;
      Neg     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= A;
        bop_q   <= sub ? ~B : B;
        carry_q <= sub;
        step_q  <= '0;
      end else if (state_q == ST_RUN) begin
        acc_q   <= acc_d;
        carry_q <= nib_cout;
        step_q  <= step_q + 1'b1;
        if (last_step) begin
          Sum  <= acc_d;
          Cout <= nib_cout;
          Ovfl <= nib_cmsb ^ nib_cout;
          Zero <= (acc_d == '0);
          Neg  <= acc_d[WIDTH-1];
        end
      end
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_addsub_seq_16bit.sv
module tb_addsub_seq_16bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        ovfl;
  logic        cout;
  logic        zero;
  logic        neg;

  int checks   = 0;
  int failures = 0;

  addsub_seq_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .Sum   (sum),
    .Ovfl  (ovfl),
    .Cout  (cout),
    .Zero  (zero),
    .Neg   (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Drive a request before a rising edge and drop start just after it.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic sv);
    @(negedge clk);
    a     = av;
    b     = bv;
    sub   = sv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Starting just after an accepting edge, step edges until done is seen
  // (bounded). Counts busy samples and whether Sum stayed at hold meanwhile.
  task automatic wait_done(input logic [15:0] hold, output int edges,
                           output int busy_cyc, output logic held_ok);
    edges    = 0;
    busy_cyc = 0;
    held_ok  = 1'b1;
    while (!done && edges < 20) begin
      if (busy) busy_cyc++;
      if (sum !== hold) held_ok = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic check_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic sv, input logic [15:0] exp_sum, input logic exp_ov,
                          input logic exp_co, input logic exp_z, input logic exp_n);
    logic [15:0] hold;
    int          edges;
    int          busy_cyc;
    logic        held_ok;
    hold = sum;
    issue(av, bv, sv);
    wait_done(hold, edges, busy_cyc, held_ok);
    // done is visible after the 4th edge following acceptance (5th cycle
    // counting the accepting cycle).
    chk16({tag, ".latency"}, 16'(edges), 16'd4);
    chk16({tag, ".busy_cycles"}, 16'(busy_cyc), 16'd4);
    chk1({tag, ".sum_held"}, held_ok, 1'b1);
    chk1({tag, ".done"}, done, 1'b1);
    chk1({tag, ".busy_in_done"}, busy, 1'b0);
    chk16({tag, ".sum"}, sum, exp_sum);
    chk1({tag, ".ovfl"}, ovfl, exp_ov);
    chk1({tag, ".cout"}, cout, exp_co);
    chk1({tag, ".zero"}, zero, exp_z);
    chk1({tag, ".neg"}, neg, exp_n);
    @(posedge clk);
    #1;
    chk1({tag, ".done_single"}, done, 1'b0);
  endtask

  initial begin
    int          edges;
    int          busy_cyc;
    logic        held_ok;
    logic        seen_done;

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk16("rst.sum", sum, 16'h0000);
    chk1("rst.ovfl", ovfl, 1'b0);
    chk1("rst.cout", cout, 1'b0);
    chk1("rst.zero", zero, 1'b0);
    chk1("rst.neg", neg, 1'b0);
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic vectors
    check_op("add",      16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0);
    check_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);
    check_op("sub_zero", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    check_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset during RUN step 2 (outputs currently 0x7FFF, Ovfl=1, Cout=1)
    issue(16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk1("mid_rst.busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk16("mid_rst.sum", sum, 16'h0000);
    chk1("mid_rst.ovfl", ovfl, 1'b0);
    chk1("mid_rst.cout", cout, 1'b0);
    chk1("mid_rst.neg", neg, 1'b0);
    chk1("mid_rst.busy", busy, 1'b0);
    chk1("mid_rst.done", done, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    seen_done = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    chk1("mid_rst.no_done", seen_done, 1'b0);
    check_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

    // start during busy, with operands changing mid-RUN, is ignored
    issue(16'h0010, 16'h0020, 1'b0);
    @(negedge clk);
    a     = 16'hFFFF;
    b     = 16'h0001;
    sub   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(16'h0002, edges, busy_cyc, held_ok);
    chk16("ignore.latency", 16'(edges + 1), 16'd4);
    chk1("ignore.sum_held", held_ok, 1'b1);
    chk1("ignore.done", done, 1'b1);
    chk16("ignore.sum", sum, 16'h0030);
    chk1("ignore.cout", cout, 1'b0);
    seen_done = 1'b0;
    @(posedge clk);
    #1;
    chk1("ignore.done_single", done, 1'b0);
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    chk1("ignore.no_second_op", seen_done, 1'b0);

    // Back-to-back: second start asserted in the DONE cycle
    issue(16'h00FF, 16'h0001, 1'b0);
    wait_done(16'h0030, edges, busy_cyc, held_ok);
    chk16("b2b.first_latency", 16'(edges), 16'd4);
    chk1("b2b.first_done", done, 1'b1);
    chk16("b2b.first_sum", sum, 16'h0100);
    a     = 16'hFFFF;
    b     = 16'h0001;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk1("b2b.accept_busy", busy, 1'b1);
    chk1("b2b.accept_done", done, 1'b0);
    wait_done(16'h0100, edges, busy_cyc, held_ok);
    chk16("b2b.second_latency", 16'(edges), 16'd4);
    chk16("b2b.second_busy", 16'(busy_cyc), 16'd4);
    chk1("b2b.sum_held", held_ok, 1'b1);
    chk1("b2b.second_done", done, 1'b1);
    chk16("b2b.second_sum", sum, 16'h0000);
    chk1("b2b.second_cout", cout, 1'b1);
    chk1("b2b.second_zero", zero, 1'b1);
    chk1("b2b.second_ovfl", ovfl, 1'b0);
    chk1("b2b.second_neg", neg, 1'b0);
    @(posedge clk);
    #1;
    chk1("b2b.done_single", done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
